// File: rtl/lcd_bus_reader_pkg.sv
// Shared definitions for the LCD read engine: state encodings, default bus
// timing in 50 MHz clock cycles, and the busy-flag position in a status byte.
package lcd_bus_reader_pkg;

  typedef enum logic [2:0] {
    LCDR_IDLE   = 3'd0,
    LCDR_SETUP  = 3'd1,
    LCDR_E_HI_U = 3'd2,
    LCDR_GAP_N  = 3'd3,
    LCDR_E_HI_L = 3'd4,
    LCDR_HOLD   = 3'd5,
    LCDR_DONE   = 3'd6,
    LCDR_GAP_P  = 3'd7
  } lcdr_state_t;

  localparam int LCD_SETUP_CYCLES      = 2;
  localparam int LCD_E_HIGH_CYCLES     = 12;
  localparam int LCD_NIBBLE_GAP_CYCLES = 50;
  localparam int LCD_HOLD_CYCLES       = 1;
  localparam int LCD_POLL_LIMIT        = 255;

  localparam int LCD_BF_BIT = 7;

  // The delay counter counts N-1 down to 0, so a phase of N cycles loads N-1.
  function automatic logic [7:0] cyclesToLoad(input int cycles);
    return 8'(cycles - 1);
  endfunction

endpackage

// File: rtl/lcd_bus_reader_delay_counter.sv
// Saturating 8-bit down-counter that times every phase of an LCD read.
module lcd_delay_counter (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iLoad,
  input  logic [7:0] iLoadValue,
  output logic       oZero
);

  logic [7:0] r_count;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_count <= 8'd0;
    end else if (iLoad) begin
      r_count <= iLoadValue;
    end else if (r_count != 8'd0) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign oZero = (r_count == 8'd0);

endmodule

// File: rtl/lcd_bus_reader.sv
// Read-side engine for the 4-bit HD44780 bus: two E strobes per byte, upper
// nibble first, with optional busy-flag polling on status reads.
module lcd_bus_reader
  import lcd_bus_reader_pkg::*;
#(
  parameter int SETUP_CYCLES      = LCD_SETUP_CYCLES,
  parameter int E_HIGH_CYCLES     = LCD_E_HIGH_CYCLES,
  parameter int NIBBLE_GAP_CYCLES = LCD_NIBBLE_GAP_CYCLES,
  parameter int HOLD_CYCLES       = LCD_HOLD_CYCLES,
  parameter int POLL_LIMIT        = LCD_POLL_LIMIT
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iStart,
  input  logic       iRS,
  input  logic       iPollBusy,
  input  logic [3:0] iLCD_Data,
  output logic       oLCD_E,
  output logic       oLCD_RS,
  output logic       oLCD_RW,
  output logic       oBusActive,
  output logic [7:0] oData,
  output logic       oValid,
  output logic       oTimeout
);

  localparam logic [7:0] L_SETUP      = cyclesToLoad(SETUP_CYCLES);
  localparam logic [7:0] L_E_HIGH     = cyclesToLoad(E_HIGH_CYCLES);
  localparam logic [7:0] L_GAP        = cyclesToLoad(NIBBLE_GAP_CYCLES);
  localparam logic [7:0] L_HOLD       = cyclesToLoad(HOLD_CYCLES);
  localparam logic [7:0] L_POLL_LIMIT = 8'(POLL_LIMIT);

  lcdr_state_t r_state;
  logic        r_poll;
  logic        r_pollAgain;
  logic [7:0]  r_pollCount;
  logic [3:0]  r_upper;
  logic [3:0]  r_lower;

  logic        w_zero;
  logic        w_load;
  logic [7:0]  w_loadValue;
  logic [7:0]  w_byte;

  assign w_byte = {r_upper, r_lower};

  lcd_delay_counter u_delay (
    .Clock      (Clock),
    .Reset      (Reset),
    .iLoad      (w_load),
    .iLoadValue (w_loadValue),
    .oZero      (w_zero)
  );

  // The counter is reloaded with the length of whichever phase comes next.
  always_comb begin
    w_load      = 1'b0;
    w_loadValue = 8'd0;
    case (r_state)
      LCDR_IDLE: begin
        w_load      = iStart;
        w_loadValue = L_SETUP;
      end
      LCDR_SETUP, LCDR_GAP_N, LCDR_GAP_P: begin
        w_load      = w_zero;
        w_loadValue = L_E_HIGH;
      end
      LCDR_E_HI_U: begin
        w_load      = w_zero;
        w_loadValue = L_GAP;
      end
      LCDR_E_HI_L: begin
        w_load      = w_zero;
        w_loadValue = L_HOLD;
      end
      LCDR_DONE: begin
        w_load      = r_pollAgain;
        w_loadValue = L_GAP;
      end
      default: begin
        w_load      = 1'b0;
        w_loadValue = 8'd0;
      end
    endcase
  end

  // Outputs for DONE are decided on the way out of HOLD so that oValid and
  // oTimeout are visible during the DONE cycle itself.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state     <= LCDR_IDLE;
      r_poll      <= 1'b0;
      r_pollAgain <= 1'b0;
      r_pollCount <= 8'd0;
      r_upper     <= 4'd0;
      r_lower     <= 4'd0;
      oLCD_E      <= 1'b0;
      oLCD_RS     <= 1'b0;
      oLCD_RW     <= 1'b0;
      oBusActive  <= 1'b0;
      oData       <= 8'h00;
      oValid      <= 1'b0;
      oTimeout    <= 1'b0;
    end else begin
      oValid   <= 1'b0;
      oTimeout <= 1'b0;
      case (r_state)
        LCDR_IDLE: begin
          if (iStart) begin
            r_poll      <= iPollBusy & ~iRS;
            r_pollCount <= 8'd1;
            oLCD_RS     <= iRS;
            oLCD_RW     <= 1'b1;
            oBusActive  <= 1'b1;
            oLCD_E      <= 1'b0;
            r_state     <= LCDR_SETUP;
          end
        end
        LCDR_SETUP: begin
          if (w_zero) begin
            oLCD_E  <= 1'b1;
            r_state <= LCDR_E_HI_U;
          end
        end
        LCDR_E_HI_U: begin
          if (w_zero) begin
            r_upper <= iLCD_Data;
            oLCD_E  <= 1'b0;
            r_state <= LCDR_GAP_N;
          end
        end
        LCDR_GAP_N: begin
          if (w_zero) begin
            oLCD_E  <= 1'b1;
            r_state <= LCDR_E_HI_L;
          end
        end
        LCDR_E_HI_L: begin
          if (w_zero) begin
            r_lower <= iLCD_Data;
            oLCD_E  <= 1'b0;
            r_state <= LCDR_HOLD;
          end
        end
        LCDR_HOLD: begin
          if (w_zero) begin
            r_state <= LCDR_DONE;
            if (!r_poll || !w_byte[LCD_BF_BIT]) begin
              oData       <= w_byte;
              oValid      <= 1'b1;
              r_pollAgain <= 1'b0;
            end else if (r_pollCount < L_POLL_LIMIT) begin
              r_pollAgain <= 1'b1;
            end else begin
              oData       <= w_byte;
              oTimeout    <= 1'b1;
              r_pollAgain <= 1'b0;
            end
          end
        end
        LCDR_DONE: begin
          if (r_pollAgain) begin
            r_pollCount <= r_pollCount + 8'd1;
            r_state     <= LCDR_GAP_P;
          end else begin
            oBusActive <= 1'b0;
            oLCD_RW    <= 1'b0;
            oLCD_RS    <= 1'b0;
            r_state    <= LCDR_IDLE;
          end
        end
        LCDR_GAP_P: begin
          if (w_zero) begin
            oLCD_E  <= 1'b1;
            r_state <= LCDR_E_HI_U;
          end
        end
        default: r_state <= LCDR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Directed bench for lcd_bus_reader: an LCD bus model serves one nibble per
// E strobe from a table of bytes, and every read is timed edge by edge.
module tb_lcd_bus_reader;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       iStart = 1'b0;
  logic       iRS = 1'b0;
  logic       iPollBusy = 1'b0;
  logic [3:0] iLCD_Data;
  logic       oLCD_E, oLCD_RS, oLCD_RW, oBusActive, oValid, oTimeout;
  logic [7:0] oData;

  int compareCount = 0;
  int mismatchCount = 0;

  int ePulses = 0;
  int pulseBase = 0;
  int modelIdx;
  logic [7:0] modelBytes [0:7];
  logic [7:0] modelByte;

  int obsRises, obsFalls, obsRise0, obsRise1, obsFall0, obsFall1;
  int obsValidCount, obsValidEdge, obsTimeoutCount, obsEndEdge, obsRsBad;
  logic [7:0] obsValidData, obsTimeoutData;
  int waitCycles;
  logic reachedLow;

  lcd_bus_reader #(.POLL_LIMIT(4)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .iStart     (iStart),
    .iRS        (iRS),
    .iPollBusy  (iPollBusy),
    .iLCD_Data  (iLCD_Data),
    .oLCD_E     (oLCD_E),
    .oLCD_RS    (oLCD_RS),
    .oLCD_RW    (oLCD_RW),
    .oBusActive (oBusActive),
    .oData      (oData),
    .oValid     (oValid),
    .oTimeout   (oTimeout)
  );

  always #10 Clock = ~Clock;

  // Each completed E strobe advances the model to the next nibble.
  always @(negedge oLCD_E) ePulses = ePulses + 1;

  always_comb begin
    modelIdx = (ePulses - pulseBase) / 2;
    if (modelIdx > 7) modelIdx = 7;
    if (modelIdx < 0) modelIdx = 0;
    modelByte = modelBytes[modelIdx];
    iLCD_Data = ((ePulses - pulseBase) % 2 == 0) ? modelByte[7:4] : modelByte[3:0];
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic setModel(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] bRest);
    modelBytes[0] = b0;
    modelBytes[1] = b1;
    modelBytes[2] = b2;
    for (int i = 3; i < 8; i++) modelBytes[i] = bRest;
  endtask

  // Called just after the acceptance edge; edge numbers are relative to it.
  task automatic observeRead(input logic rs, input int budget);
    logic prevE;
    obsRises = 0; obsFalls = 0; obsRise0 = -1; obsRise1 = -1; obsFall0 = -1; obsFall1 = -1;
    obsValidCount = 0; obsValidEdge = -1; obsTimeoutCount = 0; obsEndEdge = -1; obsRsBad = 0;
    obsValidData = 8'h00; obsTimeoutData = 8'h00;
    prevE = oLCD_E;
    for (int c = 1; c <= budget; c++) begin
      @(posedge Clock);
      #1;
      if (oLCD_E && !prevE) begin
        if (obsRises == 0) obsRise0 = c;
        else if (obsRises == 1) obsRise1 = c;
        obsRises++;
      end
      if (!oLCD_E && prevE) begin
        if (obsFalls == 0) obsFall0 = c;
        else if (obsFalls == 1) obsFall1 = c;
        obsFalls++;
      end
      prevE = oLCD_E;
      if (oBusActive && (oLCD_RS !== rs || oLCD_RW !== 1'b1)) obsRsBad++;
      if (oValid) begin
        obsValidCount++;
        obsValidEdge = c;
        obsValidData = oData;
      end
      if (oTimeout) begin
        obsTimeoutCount++;
        obsTimeoutData = oData;
      end
      if (!oBusActive) begin
        obsEndEdge = c;
        break;
      end
    end
    checkOutput("readFinished", 32'(obsEndEdge > 0), 32'd1);
  endtask

  task automatic applyStimulus(input logic rs, input logic poll, input int budget);
    pulseBase = ePulses;
    @(negedge Clock);
    iRS = rs;
    iPollBusy = poll;
    iStart = 1'b1;
    @(posedge Clock);
    #1;
    iStart = 1'b0;
    observeRead(rs, budget);
  endtask

  initial begin
    setModel(8'h00, 8'h00, 8'h00, 8'h00);
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    checkOutput("rstE", 32'(oLCD_E), 32'd0);
    checkOutput("rstRS", 32'(oLCD_RS), 32'd0);
    checkOutput("rstRW", 32'(oLCD_RW), 32'd0);
    checkOutput("rstBusActive", 32'(oBusActive), 32'd0);
    checkOutput("rstData", 32'(oData), 32'h00);
    checkOutput("rstValid", 32'(oValid), 32'd0);
    checkOutput("rstTimeout", 32'(oTimeout), 32'd0);

    // Status read
    setModel(8'h3A, 8'h3A, 8'h3A, 8'h3A);
    applyStimulus(1'b0, 1'b0, 400);
    checkOutput("statPulses", 32'(obsRises), 32'd2);
    checkOutput("statFirstRise", 32'(obsRise0), 32'd2);
    checkOutput("statWidth0", 32'(obsFall0 - obsRise0), 32'd12);
    checkOutput("statGap", 32'(obsRise1 - obsFall0), 32'd50);
    checkOutput("statWidth1", 32'(obsFall1 - obsRise1), 32'd12);
    checkOutput("statValidEdge", 32'(obsValidEdge), 32'd77);
    checkOutput("statValidCount", 32'(obsValidCount), 32'd1);
    checkOutput("statData", 32'(obsValidData), 32'h3A);
    checkOutput("statBusDrop", 32'(obsEndEdge), 32'd78);
    checkOutput("statRsRw", 32'(obsRsBad), 32'd0);
    checkOutput("statTimeout", 32'(obsTimeoutCount), 32'd0);
    checkOutput("idleRW", 32'(oLCD_RW), 32'd0);

    // Data read
    setModel(8'h41, 8'h41, 8'h41, 8'h41);
    applyStimulus(1'b1, 1'b0, 400);
    checkOutput("dataValue", 32'(obsValidData), 32'h41);
    checkOutput("dataValidCount", 32'(obsValidCount), 32'd1);
    checkOutput("dataRsRw", 32'(obsRsBad), 32'd0);
    checkOutput("dataPulses", 32'(obsRises), 32'd2);
    checkOutput("idleRS", 32'(oLCD_RS), 32'd0);

    // Poll request with RS=1 is a plain data read even when BF is set
    setModel(8'hC5, 8'h80, 8'h80, 8'h80);
    applyStimulus(1'b1, 1'b1, 400);
    checkOutput("pollRs1Pulses", 32'(obsRises), 32'd2);
    checkOutput("pollRs1Data", 32'(obsValidData), 32'hC5);
    checkOutput("pollRs1Valid", 32'(obsValidCount), 32'd1);

    // Poll, busy clears on the fourth read
    setModel(8'h80, 8'hA2, 8'hFF, 8'h05);
    applyStimulus(1'b0, 1'b1, 2000);
    checkOutput("pollPulses", 32'(obsRises), 32'd8);
    checkOutput("pollValidCount", 32'(obsValidCount), 32'd1);
    checkOutput("pollData", 32'(obsValidData), 32'h05);
    checkOutput("pollTimeout", 32'(obsTimeoutCount), 32'd0);
    checkOutput("pollRsRw", 32'(obsRsBad), 32'd0);

    // Poll, stuck busy until the limit of four reads
    setModel(8'h80, 8'h80, 8'h80, 8'h80);
    applyStimulus(1'b0, 1'b1, 2000);
    checkOutput("toPulses", 32'(obsRises), 32'd8);
    checkOutput("toCount", 32'(obsTimeoutCount), 32'd1);
    checkOutput("toData", 32'(obsTimeoutData), 32'h80);
    checkOutput("toValid", 32'(obsValidCount), 32'd0);
    checkOutput("toFinalData", 32'(oData), 32'h80);

    // Reset while the lower nibble strobe is high
    setModel(8'h99, 8'h99, 8'h99, 8'h99);
    pulseBase = ePulses;
    @(negedge Clock);
    iRS = 1'b0;
    iPollBusy = 1'b0;
    iStart = 1'b1;
    @(posedge Clock);
    #1;
    iStart = 1'b0;
    reachedLow = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(posedge Clock);
      #1;
      if ((ePulses - pulseBase) == 1 && oLCD_E) begin
        reachedLow = 1'b1;
        break;
      end
    end
    checkOutput("midReachedLowStrobe", 32'(reachedLow), 32'd1);
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    checkOutput("midRstE", 32'(oLCD_E), 32'd0);
    checkOutput("midRstBusActive", 32'(oBusActive), 32'd0);
    checkOutput("midRstValid", 32'(oValid), 32'd0);
    checkOutput("midRstData", 32'(oData), 32'h00);
    @(negedge Clock);
    Reset = 1'b0;
    setModel(8'h5C, 8'h5C, 8'h5C, 8'h5C);
    applyStimulus(1'b0, 1'b0, 400);
    checkOutput("afterRstData", 32'(obsValidData), 32'h5C);
    checkOutput("afterRstValid", 32'(obsValidCount), 32'd1);

    // iStart held high across a whole read
    setModel(8'h27, 8'h6E, 8'h6E, 8'h6E);
    pulseBase = ePulses;
    @(negedge Clock);
    iRS = 1'b0;
    iPollBusy = 1'b0;
    iStart = 1'b1;
    @(posedge Clock);
    #1;
    observeRead(1'b0, 400);
    checkOutput("holdPulses", 32'(obsRises), 32'd2);
    checkOutput("holdValidCount", 32'(obsValidCount), 32'd1);
    checkOutput("holdData", 32'(obsValidData), 32'h27);
    checkOutput("holdValidEdge", 32'(obsValidEdge), 32'd77);
    @(posedge Clock);
    #1;
    checkOutput("holdRestart", 32'(oBusActive), 32'd1);
    iStart = 1'b0;
    observeRead(1'b0, 400);
    checkOutput("restartPulses", 32'(obsRises), 32'd2);
    checkOutput("restartData", 32'(obsValidData), 32'h6E);
    waitCycles = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge Clock);
      #1;
      if (oBusActive) waitCycles++;
    end
    checkOutput("noThirdRead", 32'(waitCycles), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
